fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/simple_pkg.sv | 17 +
 rtl/fetch_stage.sv | 57 +++++
 tb/tb_fetch_stage.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simple_pkg.sv
// rtl/simple_pkg.sv - shared encodings for the fetch stage and decoder
package simple_pkg;

    localparam logic [15:0] NOP_INST = 16'hC0E0;
    localparam logic [1:0]  HLT_OP   = 2'b11;
    localparam logic [3:0]  HLT_FUNC = 4'b1111;

    typedef enum logic {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_e;

    function automatic logic is_hlt(input logic [15:0] inst);
        return (inst[15:14] == HLT_OP) && (inst[7:4] == HLT_FUNC);
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, IF/ID register, run/halt FSM and fetch counter
import simple_pkg::*;

module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] id_inst,
    output logic [15:0] id_pc1,
    output logic        id_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    logic [15:0]  pc;
    logic [15:0]  pc_inc;
    fetch_state_e state;

    assign pc_inc    = pc + 16'd1;
    assign imem_addr = pc;
    assign halted    = (state == FETCH_HALTED);

    // Redirect outranks stall so a taken branch can never be lost behind a hazard hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= 16'h0000;
            id_inst     <= NOP_INST;
            id_pc1      <= 16'h0000;
            id_valid    <= 1'b0;
            state       <= FETCH_RUN;
            fetch_count <= 16'h0000;
        end else if (redirect) begin
            pc       <= redirect_pc;
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
            state    <= FETCH_RUN;
        end else if (stall) begin
            pc       <= pc;
        end else if (state == FETCH_HALTED) begin
            id_inst  <= NOP_INST;
            id_valid <= 1'b0;
        end else begin
            id_inst     <= imem_rdata;
            id_pc1      <= pc_inc;
            id_valid    <= 1'b1;
            pc          <= pc_inc;
            fetch_count <= fetch_count + 16'd1;
            if (is_hlt(imem_rdata))
                state <= FETCH_HALTED;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [15:0] BUBBLE = 16'hC0E0;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] id_inst;
    logic [15:0] id_pc1;
    logic        id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    logic [15:0] m_pc, m_inst, m_pc1, m_count;
    logic        m_valid, m_halted;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_inst     (id_inst),
        .id_pc1      (id_pc1),
        .id_valid    (id_valid),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    assign imem_rdata = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic hlt_word(input logic [15:0] w);
        return (w[15:14] == 2'b11) && (w[7:4] == 4'b1111);
    endfunction

    task automatic model_reset();
        m_pc = 16'h0; m_inst = BUBBLE; m_pc1 = 16'h0; m_count = 16'h0;
        m_valid = 1'b0; m_halted = 1'b0;
    endtask

    // One clock of architectural behaviour, applied to the model, then to the DUT.
    task automatic cycle(input logic s, input logic r, input logic [15:0] rpc);
        logic [15:0] w;
        stall = s; redirect = r; redirect_pc = rpc;
        w = mem[m_pc];
        if (r) begin
            m_pc = rpc; m_inst = BUBBLE; m_valid = 1'b0; m_halted = 1'b0;
        end else if (s) begin
            m_pc = m_pc;
        end else if (m_halted) begin
            m_inst = BUBBLE; m_valid = 1'b0;
        end else begin
            m_inst = w; m_pc1 = m_pc + 16'd1; m_valid = 1'b1;
            m_pc = m_pc + 16'd1; m_count = m_count + 16'd1;
            if (hlt_word(w)) m_halted = 1'b1;
        end
        @(posedge clk);
        #1;
        stall = 1'b0; redirect = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            v[4] = 1'b0;
            mem[i] = v;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        #2;
        checks++;
        if ({imem_addr, id_inst, id_pc1, id_valid, halted, fetch_count} !==
            {16'h0, BUBBLE, 16'h0, 1'b0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL reset_state: addr=%h inst=%h pc1=%h v=%b h=%b cnt=%h required 0000 c0e0 0000 0 0 0000",
                     imem_addr, id_inst, id_pc1, id_valid, halted, fetch_count);
        end
    endtask

    task automatic test_first_fetch();
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            logic [15:0] exp_inst;
            exp_inst = 16'h1111 * 16'(i + 1);
            cycle(1'b0, 1'b0, 16'h0);
            checks++;
            if (id_inst !== exp_inst || id_pc1 !== 16'(i + 1) || id_valid !== 1'b1) begin
                errors++;
                $display("FAIL first_fetch[%0d]: inst=%h pc1=%h v=%b required %h %h 1",
                         i, id_inst, id_pc1, id_valid, exp_inst, 16'(i + 1));
            end
        end
        checks++;
        if (fetch_count !== 16'd3) begin
            errors++;
            $display("FAIL first_fetch_count: got %0d required 3", fetch_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 16'h0);
        checks++;
        if (id_inst !== 16'h2222 || imem_addr !== 16'd2 || fetch_count !== 16'd2 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: inst=%h addr=%h cnt=%h v=%b required 2222 0002 0002 1",
                     id_inst, imem_addr, fetch_count, id_valid);
        end
        cycle(1'b0, 1'b0, 16'h0);
        checks++;
        if (id_inst !== 16'h3333 || id_pc1 !== 16'd3 || fetch_count !== 16'd3) begin
            errors++;
            $display("FAIL stall_resume: inst=%h pc1=%h cnt=%h required 3333 0003 0003",
                     id_inst, id_pc1, fetch_count);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 16'h0040);
        checks++;
        if (id_valid !== 1'b0 || id_inst !== BUBBLE || imem_addr !== 16'h0040) begin
            errors++;
            $display("FAIL redirect: v=%b inst=%h addr=%h required 0 c0e0 0040", id_valid, id_inst, imem_addr);
        end
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b1, 16'h0040);
        checks++;
        if (id_valid !== 1'b0 || id_inst !== BUBBLE || imem_addr !== 16'h0040) begin
            errors++;
            $display("FAIL redirect_stall: v=%b inst=%h addr=%h required 0 c0e0 0040", id_valid, id_inst, imem_addr);
        end
        cycle(1'b0, 1'b0, 16'h0);
        checks++;
        if (id_inst !== mem[16'h0040] || id_pc1 !== 16'h0041 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL redirect_fetch: inst=%h pc1=%h v=%b required %h 0041 1",
                     id_inst, id_pc1, id_valid, mem[16'h0040]);
        end
    endtask

    task automatic test_halt();
        mem[5] = 16'hC0F0;
        do_reset();
        repeat (5) cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 16'h0);
        checks++;
        if (id_inst !== 16'hC0F0 || id_valid !== 1'b1 || halted !== 1'b1 || imem_addr !== 16'd6) begin
            errors++;
            $display("FAIL halt_latch: inst=%h v=%b h=%b addr=%h required c0f0 1 1 0006",
                     id_inst, id_valid, halted, imem_addr);
        end
        repeat (3) cycle(1'b0, 1'b0, 16'h0);
        checks++;
        if (id_inst !== BUBBLE || id_valid !== 1'b0 || halted !== 1'b1 ||
            imem_addr !== 16'd6 || fetch_count !== 16'd6) begin
            errors++;
            $display("FAIL halt_hold: inst=%h v=%b h=%b addr=%h cnt=%h required c0e0 0 1 0006 0006",
                     id_inst, id_valid, halted, imem_addr, fetch_count);
        end
        cycle(1'b0, 1'b1, 16'h0010);
        cycle(1'b0, 1'b0, 16'h0);
        checks++;
        if (halted !== 1'b0 || id_inst !== mem[16'h0010] || id_valid !== 1'b1 || fetch_count !== 16'd7) begin
            errors++;
            $display("FAIL halt_resume: h=%b inst=%h v=%b cnt=%h required 0 %h 1 0007",
                     halted, id_inst, id_valid, fetch_count, mem[16'h0010]);
        end
        mem[5] = 16'h0505;
    endtask

    task automatic test_redirect_hlt();
        mem[2] = 16'hFFF3;
        do_reset();
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 16'h0020);
        checks++;
        if (halted !== 1'b0 || id_inst !== BUBBLE || imem_addr !== 16'h0020) begin
            errors++;
            $display("FAIL redirect_hlt: h=%b inst=%h addr=%h required 0 c0e0 0020", halted, id_inst, imem_addr);
        end
        cycle(1'b0, 1'b0, 16'h0);
        checks++;
        if (halted !== 1'b0 || id_inst !== mem[16'h0020] || fetch_count !== 16'd3) begin
            errors++;
            $display("FAIL redirect_hlt_after: h=%b inst=%h cnt=%h required 0 %h 0003",
                     halted, id_inst, fetch_count, mem[16'h0020]);
        end
        mem[2] = 16'h3333;
    endtask

    task automatic test_wrap_and_async_reset();
        mem[16'hFFFF] = 16'h1234;
        do_reset();
        cycle(1'b0, 1'b1, 16'hFFFF);
        cycle(1'b0, 1'b0, 16'h0);
        checks++;
        if (id_inst !== 16'h1234 || id_pc1 !== 16'h0000 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL pc_wrap: inst=%h pc1=%h addr=%h required 1234 0000 0000", id_inst, id_pc1, imem_addr);
        end
        cycle(1'b0, 1'b0, 16'h0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({imem_addr, id_inst, id_pc1, id_valid, halted, fetch_count} !==
            {16'h0, BUBBLE, 16'h0, 1'b0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL async_reset: addr=%h inst=%h pc1=%h v=%b h=%b cnt=%h required 0000 c0e0 0000 0 0 0000",
                     imem_addr, id_inst, id_pc1, id_valid, halted, fetch_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 256; i++)
            if ($urandom_range(0, 9) == 0) mem[i] = 16'hC0F0 | 16'($urandom_range(0, 15));
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic s, r;
            logic [15:0] t;
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 9) == 0);
            t = 16'($urandom_range(0, 255));
            cycle(s, r, t);
            checks++;
            if (imem_addr !== m_pc || id_inst !== m_inst || id_pc1 !== m_pc1 || id_valid !== m_valid ||
                halted !== m_halted || fetch_count !== m_count) begin
                errors++;
                $display("FAIL random[%0d]: addr=%h inst=%h pc1=%h v=%b h=%b cnt=%h required %h %h %h %b %b %h",
                         n, imem_addr, id_inst, id_pc1, id_valid, halted, fetch_count,
                         m_pc, m_inst, m_pc1, m_valid, m_halted, m_count);
            end
        end
    endtask

    initial begin
        stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; rst = 1'b1;
        fill_mem();
        test_reset();
        test_first_fetch();
        test_stall();
        test_redirect();
        test_halt();
        test_redirect_hlt();
        test_wrap_and_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
